// File: rtl/frame_load_ctrl.sv
// Streams one frame from a synchronous-read frame buffer to a ready/valid sink on a load edge.
// Optional macro FRAME_LOAD_CTRL_ABORT_EN: load falling mid-frame aborts the transfer.
module frame_load_ctrl #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAME_WORDS = 76800
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_WORDS - 1);

  state_e            state_q, state_d;
  logic              load_q;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;

  logic start, abort, pop, push, room;

  assign start = load & ~load_q;

`ifdef FRAME_LOAD_CTRL_ABORT_EN
  assign abort = ~load & load_q & (state_q != StIdle);
`else
  assign abort = 1'b0;
`endif

  assign pix_valid = (occ_q != 2'd0);
  assign pix_data  = fifo_q[rd_ptr_q];
  assign pop       = pix_valid & pix_ready;
  // An aborted frame drops the datum returning this cycle.
  assign push      = inflight_q & ~abort;
  // Never have more words buffered plus outstanding than the FIFO can hold.
  assign room      = ({1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;

  assign rd_addr = rd_en ? count_q : addr_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          count_d = '0;
          done_d  = 1'b0;
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
        end else if (room) begin
          rd_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LastAddr) state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!inflight_q && ((occ_q - {1'b0, pop}) == 2'd0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      load_q     <= 1'b0;
      count_q    <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load;
      count_q    <= count_d;
      done_q     <= done_d;
      inflight_q <= rd_en;
      if (rd_en) addr_q <= count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else if (abort) begin
      rd_ptr_q <= wr_ptr_q;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Bench for frame_load_ctrl: vector table, corner-case sequences and randomized traffic
// checked cycle by cycle against a transaction-level model of the frame transfer.
module tb_frame_load_ctrl;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load = 1'b0;
  logic          pix_ready = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_en, pix_valid, busy, done;
  logic [DW-1:0] pix_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_load_ctrl #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FRAME_WORDS(FW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .busy     (busy),
    .done     (done)
  );

  // Frame buffer: word = 0x100 + address, returned the cycle after the strobe.
  always @(posedge clk) if (rd_en) rd_data <= DW'(32'h100 + 32'(rd_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected event (t=%0t)", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_active, m_done, m_load_prev, m_stall_prev;
  int            m_issued, m_xfers, m_cyc;
  int            issue_cyc[$];
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_prev_data;
  int            tot_rd = 0, tot_xfer = 0, done_rises = 0;
  bit            done_prev;

  always @(negedge clk) begin
    int landed;
    bit mv, mpop, mstart, mabort, exp_rd;
    if (!reset_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_data", pix_data, 0);
      m_active = 0; m_done = 0; m_load_prev = 0; m_stall_prev = 0;
      m_issued = 0; m_xfers = 0; m_last_addr = '0;
      issue_cyc.delete();
      done_prev = 0;
    end else begin
      m_cyc++;
      landed = 0;
      foreach (issue_cyc[i]) if (issue_cyc[i] <= m_cyc - 2) landed++;
      mv     = m_active && (landed > m_xfers);
      mpop   = mv && pix_ready;
      mstart = !m_active && load && !m_load_prev;
`ifdef FRAME_LOAD_CTRL_ABORT_EN
      mabort = m_active && !load && m_load_prev;
`else
      mabort = 0;
`endif
      exp_rd = m_active && !mabort && (m_issued < FW) && ((m_issued - m_xfers - int'(mpop)) < 2);

      check("busy", busy, m_active);
      check("done", done, m_done);
      check("pix_valid", pix_valid, mv);
      check("rd_en", rd_en, exp_rd);
      if (rd_en) check("rd_addr", rd_addr, m_issued);
      else check("rd_addr_hold", rd_addr, m_last_addr);
      if (m_stall_prev && pix_valid) check("stall_hold", pix_data, m_prev_data);
      if (mpop) check("pix_data", pix_data, 32'h100 + m_xfers);

      if (rd_en) tot_rd++;
      if (pix_valid && pix_ready) tot_xfer++;
      if (done && !done_prev) done_rises++;
      done_prev = done;

      if (exp_rd) begin
        issue_cyc.push_back(m_cyc);
        m_last_addr = AW'(m_issued);
        m_issued++;
      end
      if (mpop) begin
        m_xfers++;
        if (m_xfers == FW) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      if (mabort) m_active = 0;
      if (mstart) begin
        m_active = 1; m_done = 0; m_issued = 0; m_xfers = 0;
        issue_cyc.delete();
      end
      m_stall_prev = pix_valid && !pix_ready;
      m_prev_data  = pix_data;
      m_load_prev  = load;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic ld;
    logic rdy;
    logic busy;
    logic rd_en;
    int   addr;
    logic pv;
    int   data;
    logic done;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic level, input int max, input string name);
    for (int i = 0; i < max && busy !== level; i++) tick();
    if (busy !== level) timeout(name);
  endtask

  task automatic wait_xfers(input int base, input int n, input int max, input string name);
    for (int i = 0; i < max && (tot_xfer - base) < n; i++) tick();
    if ((tot_xfer - base) < n) timeout(name);
  endtask

  initial begin
    int s_rd, s_x, s_d;
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rd, s_x, s_d;
    //            ld   rdy  busy rd   addr pv  data     done
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0,      1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0,      1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 0,      1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 'h100,  1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 'h101,  1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1, 'h102,  1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1, 'h103,  1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 0,      1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 0,      1'b1};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic frame, one pixel per cycle.
    for (int i = 0; i < 10; i++) begin
      load = vecs[i].ld;
      pix_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_rd_en", i), rd_en, vecs[i].rd_en);
      check($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].addr);
      check($sformatf("vec%0d_pix_valid", i), pix_valid, vecs[i].pv);
      if (vecs[i].pv) check($sformatf("vec%0d_pix_data", i), pix_data, vecs[i].data);
      check($sformatf("vec%0d_done", i), done, vecs[i].done);
      tick();
    end

    // Backpressure right after the first valid pixel.
    s_rd = tot_rd; s_x = tot_xfer;
    load = 1'b1; pix_ready = 1'b0;
    for (int i = 0; i < 20 && !pix_valid; i++) tick();
    if (!pix_valid) timeout("stall_first_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pv", pix_valid, 1);
      check("stall_data", pix_data, 'h100);
      tick();
    end
    check("stall_reads", tot_rd - s_rd, 2);
    pix_ready = 1'b1;
    wait_busy(1'b0, 40, "stall_finish");
    check("stall_pixels", tot_xfer - s_x, FW);
    check("stall_done", done, 1);

`ifndef FRAME_LOAD_CTRL_ABORT_EN
    // Second load edge while busy is ignored.
    load = 1'b0; tick();
    s_x = tot_xfer; s_d = done_rises;
    load = 1'b1; tick(); tick();
    load = 1'b0; tick();
    load = 1'b1;
    wait_busy(1'b0, 40, "reedge_finish");
    tick(); tick();
    check("reedge_pixels", tot_xfer - s_x, FW);
    check("reedge_done_once", done_rises - s_d, 1);
    check("reedge_idle", busy, 0);
`endif

    // Fresh edge in idle clears done and restarts.
    load = 1'b0; tick();
    load = 1'b1; tick();
    check("restart_done_clr", done, 0);
    check("restart_busy", busy, 1);
    wait_busy(1'b0, 40, "restart_finish");

    // Reset mid-frame with load held high.
    load = 1'b0; tick();
    s_x = tot_xfer;
    load = 1'b1;
    wait_xfers(s_x, 2, 40, "rst_two_pixels");
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_pix_valid", pix_valid, 0);
    check("arst_pix_data", pix_data, 0);
    check("arst_done", done, 0);
    tick(); tick();
    @(posedge clk);
    #1 reset_n = 1'b1;
    s_x = tot_xfer;
    wait_busy(1'b1, 5, "rst_restart");
    wait_busy(1'b0, 40, "rst_frame");
    check("rst_frame_pixels", tot_xfer - s_x, FW);
    check("rst_frame_done", done, 1);

    // Load falls after one pixel.
    load = 1'b0; tick();
    s_x = tot_xfer;
    load = 1'b1;
    wait_xfers(s_x, 1, 40, "fall_one_pixel");
    load = 1'b0;
`ifdef FRAME_LOAD_CTRL_ABORT_EN
    tick();
    check("abort_busy", busy, 0);
    check("abort_pv", pix_valid, 0);
    check("abort_done", done, 0);
`else
    wait_busy(1'b0, 40, "fall_finish");
    check("fall_pixels", tot_xfer - s_x, FW);
    check("fall_done", done, 1);
`endif

    // Randomized load/ready traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) load = ~load;
      tick();
    end
    load = 1'b0; pix_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
